mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front-end sitting directly upstream of the 32-word `memory` block.
- Accepts one datapath request at a time: byte, halfword or word; load or store.
- Generates memoryRead/memoryWrite/memoryAddress/memoryWriteData for the memory.
- Sub-word stores use read-modify-write. Loads return sign/zero-extended data.
- Misaligned accesses are checked before any memory access.

Parameters:
- ENDIAN_BIG, 0: byte lane order. 0 = offset 0 is bits [7:0]; 1 = offset 0 is bits [31:24].
- FAULT_ENABLE, 1: 1 = misaligned request faults. 0 = misaligned low address bits are forced to zero and the access proceeds.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  1  request strobe; sampled only in IDLE
- reqWrite  input  1  1 = store, 0 = load
- reqSize  input  2  00 byte, 01 half, 10 word, 11 illegal
- reqUnsigned  input  1  load zero-extends when 1, sign-extends when 0
- reqAddress  input  32  byte address
- reqWriteData  input  32  store data, right-justified for sub-word stores
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- fault  output  1  one-cycle pulse, coincident with done, for misaligned/illegal requests
- loadData  output  32  extended load result; holds until the next load completes
- memoryRead  output  1  to memory
- memoryWrite  output  1  to memory
- memoryAddress  output  32  word-aligned address {addr[31:2], 2'b00}
- memoryWriteData  output  32  full merged word
- memoryOutData  input  32  from memory; combinational read, valid in the same cycle as memoryRead

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, done, fault, memoryRead, memoryWrite, memoryAddress, memoryWriteData and loadData are all 0.
  - memoryRead and memoryWrite are gated by !rst, so reset in any state produces no memory access in that cycle.
  - Reset mid-operation abandons the request. No done pulse.
- IDLE:
  - When req=1, latch reqWrite, reqSize, reqUnsigned, reqAddress and reqWriteData.
  - Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or size 11 (always illegal).
  - Misaligned and FAULT_ENABLE=1 -> FAULT.
  - Otherwise: load -> READ; word store -> WRITE; byte/half store -> READ.
  - req while busy is ignored; no queueing.
- READ:
  - memoryRead=1, memoryAddress = latched aligned address.
  - Capture memoryOutData into the word register at the clock edge.
  - Load -> DONE. loadData is updated at this edge from lane extraction and extension.
  - Store -> WRITE.
- WRITE:
  - memoryWrite=1.
  - Word store: memoryWriteData = latched data.
  - Sub-word store: the captured word with the addressed lane(s) replaced by data[7:0] or data[15:0], placed per ENDIAN_BIG.
  - Next state: DONE.
- DONE: done=1 for one cycle, then IDLE.
- FAULT: done=1 and fault=1 for one cycle, no memory strobes, loadData unchanged, then IDLE.
- Latency, counting the cycle after req is sampled as 1:
  - load: done in cycle 2
  - word store: done in cycle 2
  - sub-word store: done in cycle 3
  - fault: done in cycle 1
- Back-to-back requests: a new req is accepted in the IDLE cycle after DONE, so throughput is one request per 3–4 cycles.
- Lane extraction:
  - Byte offset = addr[1:0]; half offset = addr[1].
  - ENDIAN_BIG inverts the lane index: byte lane 3-offset, half lane 1-offset.
- Memory strobes are decoded combinationally from state. They are never both high in the same cycle.

Decomposition:
- Shared package mem_access_pkg holds:
  - size codes: SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
  - state encoding: IDLE, READ, WRITE, DONE, FAULT
- One natural sub-module, mem_lane_align (combinational). It takes word, offset, size, unsigned flag, store data and ENDIAN_BIG, and returns the extended load value and the merged store word. It is instantiated once.
- FSM and latches stay in mem_access_unit.

Test Plan:
- Setup: preload RAM[9] (address 0x24) = 0x8899AABB, ENDIAN_BIG=0.
- Signed byte load @0x25 -> done in cycle 2, loadData=0xFFFFFFAA, memoryAddress=0x24. Same with reqUnsigned=1 -> 0x000000AA.
- Signed half load @0x26 -> loadData=0xFFFF8899. Word load @0x24 -> 0x8899AABB.
- Byte store data=0x11 @0x27 -> READ, WRITE, DONE; done in cycle 3; memoryWriteData=0x1199AABB; subsequent word load returns 0x1199AABB.
- Word load @0x22 with FAULT_ENABLE=1 -> cycle 1 done=1 and fault=1; memoryRead/memoryWrite never high; loadData unchanged.
- Word store @0x24 with rst asserted in the WRITE cycle -> memoryWrite=0, no done, state IDLE, RAM[9] unchanged.
- ENDIAN_BIG=1, unsigned byte load @0x24 -> loadData=0x00000088. Also: req held high during busy -> only one access performed.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store front-end: access size codes and FSM states.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] FAULT = 3'd4;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return low[0];
      SIZE_WORD: return |low;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge for
// sub-word stores into a previously read word.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter bit ENDIAN_BIG = 1'b0
) (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [1:0]  w_byte_lane;
  logic        w_half_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // big-endian lane index is 3-offset (byte) / 1-offset (half), i.e. the bitwise inverse
    w_byte_lane = ENDIAN_BIG ? ~i_offset : i_offset;
    w_half_lane = ENDIAN_BIG ? ~i_offset[1] : i_offset[1];
    w_byte      = i_word[{w_byte_lane, 3'b000} +: 8];
    w_half      = i_word[{w_half_lane, 4'b0000} +: 16];
    o_load      = i_word;
    o_merged    = i_store_data;
    case (i_size)
      SIZE_BYTE: begin
        o_load   = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
        o_merged = i_word;
        o_merged[{w_byte_lane, 3'b000} +: 8] = i_store_data[7:0];
      end
      SIZE_HALF: begin
        o_load   = {{16{w_half[15] & ~i_unsigned}}, w_half};
        o_merged = i_word;
        o_merged[{w_half_lane, 4'b0000} +: 16] = i_store_data[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end for the 32-word memory: one request at a time,
// read-modify-write for sub-word stores, extended load results.
//
// state | meaning
// IDLE  | waiting for req; latches the request
// READ  | memoryRead, capture word (and load result)
// WRITE | memoryWrite with full or merged word
// DONE  | one-cycle completion pulse
// FAULT | done+fault pulse, no memory access
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter bit ENDIAN_BIG   = 1'b0,
  parameter bit FAULT_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] loadData,
  output logic        memoryRead,
  output logic        memoryWrite,
  output logic [31:0] memoryAddress,
  output logic [31:0] memoryWriteData,
  input  logic [31:0] memoryOutData
);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  req_t        r_req;
  logic [31:0] r_word;
  logic [31:0] r_load_data;
  logic        w_misaligned;
  logic [1:0]  w_size_eff;
  logic [31:0] w_addr_eff;
  logic [31:0] w_align_word;
  logic [31:0] w_load_value;
  logic [31:0] w_merged;

  // with faulting disabled, illegal size acts as a word and low address bits are dropped
  always_comb begin
    w_misaligned = is_misaligned(reqSize, reqAddress[1:0]);
    w_size_eff   = (reqSize == SIZE_ILL) ? SIZE_WORD : reqSize;
    w_addr_eff   = reqAddress;
    if (w_size_eff == SIZE_HALF) w_addr_eff[0] = 1'b0;
    else if (w_size_eff == SIZE_WORD) w_addr_eff[1:0] = 2'b00;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req) begin
          if (w_misaligned && FAULT_ENABLE) w_next = FAULT;
          else if (!reqWrite || (w_size_eff != SIZE_WORD)) w_next = READ;
          else w_next = WRITE;
        end
      end
      READ:    w_next = r_req.write ? WRITE : DONE;
      WRITE:   w_next = DONE;
      DONE:    w_next = IDLE;
      FAULT:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_word      <= '0;
      r_load_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req) begin
        r_req.write       <= reqWrite;
        r_req.size        <= w_size_eff;
        r_req.is_unsigned <= reqUnsigned;
        r_req.addr        <= w_addr_eff;
        r_req.wdata       <= reqWriteData;
      end
      if (r_state == READ) begin
        r_word <= memoryOutData;
        if (!r_req.write) r_load_data <= w_load_value;
      end
    end
  end

  // extraction works on the live read data so loadData updates at the READ edge
  assign w_align_word = (r_state == READ) ? memoryOutData : r_word;

  mem_lane_align #(
    .ENDIAN_BIG(ENDIAN_BIG)
  ) u_lane_align (
    .i_word      (w_align_word),
    .i_offset    (r_req.addr[1:0]),
    .i_size      (r_req.size),
    .i_unsigned  (r_req.is_unsigned),
    .i_store_data(r_req.wdata),
    .o_load      (w_load_value),
    .o_merged    (w_merged)
  );

  assign busy            = (r_state != IDLE);
  assign done            = (r_state == DONE) || (r_state == FAULT);
  assign fault           = (r_state == FAULT);
  assign loadData        = r_load_data;
  assign memoryRead      = (r_state == READ) && !rst;
  assign memoryWrite     = (r_state == WRITE) && !rst;
  assign memoryAddress   = {r_req.addr[31:2], 2'b00};
  assign memoryWriteData = (r_state == WRITE) ? w_merged : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: little-endian/faulting and big-endian/non-faulting
// instances side by side, each with its own 32-word RAM, against a reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req_write, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        busy [2];
  logic        done [2];
  logic        fault [2];
  logic        mem_rd [2];
  logic        mem_wr [2];
  logic [31:0] load_data [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] ram [2][32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx;
  logic [31:0] pl_val;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mref [2][32];
  logic [31:0] mld [2];
  int          e_lat [2], e_rd [2], e_wr [2], e_flt [2];
  int          exp_idx;
  logic [31:0] exp_addr = 32'h0;
  int          last_lat [2];

  int rd_cnt [2] = '{0, 0};
  int wr_cnt [2] = '{0, 0};
  int dn_cnt [2] = '{0, 0};
  int ft_cnt [2] = '{0, 0};
  int bh_cnt [2] = '{0, 0};
  int ae_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  mem_access_unit #(.ENDIAN_BIG(1'b0), .FAULT_ENABLE(1'b1)) u_dut_le (
    .clk(clk), .rst(rst), .req(req), .reqWrite(req_write), .reqSize(req_size),
    .reqUnsigned(req_uns), .reqAddress(req_addr), .reqWriteData(req_wdata),
    .busy(busy[0]), .done(done[0]), .fault(fault[0]), .loadData(load_data[0]),
    .memoryRead(mem_rd[0]), .memoryWrite(mem_wr[0]), .memoryAddress(mem_addr[0]),
    .memoryWriteData(mem_wdata[0]), .memoryOutData(mem_rdata[0])
  );

  mem_access_unit #(.ENDIAN_BIG(1'b1), .FAULT_ENABLE(1'b0)) u_dut_be (
    .clk(clk), .rst(rst), .req(req), .reqWrite(req_write), .reqSize(req_size),
    .reqUnsigned(req_uns), .reqAddress(req_addr), .reqWriteData(req_wdata),
    .busy(busy[1]), .done(done[1]), .fault(fault[1]), .loadData(load_data[1]),
    .memoryRead(mem_rd[1]), .memoryWrite(mem_wr[1]), .memoryAddress(mem_addr[1]),
    .memoryWriteData(mem_wdata[1]), .memoryOutData(mem_rdata[1])
  );

  assign mem_rdata[0] = ram[0][mem_addr[0][6:2]];
  assign mem_rdata[1] = ram[1][mem_addr[1][6:2]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pl_en) ram[k][pl_idx] <= pl_val;
      else if (mem_wr[k] === 1'b1) ram[k][mem_addr[k][6:2]] <= mem_wdata[k];
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_rd[k] === 1'b1) rd_cnt[k] <= rd_cnt[k] + 1;
      if (mem_wr[k] === 1'b1) wr_cnt[k] <= wr_cnt[k] + 1;
      if (done[k] === 1'b1) dn_cnt[k] <= dn_cnt[k] + 1;
      if (fault[k] === 1'b1) ft_cnt[k] <= ft_cnt[k] + 1;
      if (mem_rd[k] === 1'b1 && mem_wr[k] === 1'b1) bh_cnt[k] <= bh_cnt[k] + 1;
      if ((mem_rd[k] === 1'b1 || mem_wr[k] === 1'b1) && mem_addr[k] !== exp_addr)
        ae_cnt[k] <= ae_cnt[k] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: k=0 is little-endian with faulting, k=1 big-endian without.
  task automatic model(input int k, input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] d);
    bit          mis;
    int          off, sh;
    logic [31:0] mask, word, v;
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    exp_idx = int'(a[6:2]);
    e_flt[k] = 0;
    if (mis && k == 0) begin
      e_lat[k] = 1; e_rd[k] = 0; e_wr[k] = 0; e_flt[k] = 1;
      return;
    end
    off = int'(a[1:0]);
    case (sz)
      2'd0: begin mask = 32'hFF;   sh = 8 * ((k == 1) ? 3 - off : off); end
      2'd1: begin mask = 32'hFFFF; sh = 16 * ((k == 1) ? 1 - off / 2 : off / 2); end
      default: begin mask = 32'hFFFF_FFFF; sh = 0; end
    endcase
    word = mref[k][exp_idx];
    if (!w) begin
      v = (word >> sh) & mask;
      if (!u && mask != 32'hFFFF_FFFF && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
      mld[k] = v;
      e_lat[k] = 2; e_rd[k] = 1; e_wr[k] = 0;
    end else if (mask == 32'hFFFF_FFFF) begin
      mref[k][exp_idx] = d;
      e_lat[k] = 2; e_rd[k] = 0; e_wr[k] = 1;
    end else begin
      mref[k][exp_idx] = (word & ~(mask << sh)) | ((d & mask) << sh);
      e_lat[k] = 3; e_rd[k] = 1; e_wr[k] = 1;
    end
  endtask

  task automatic pre(input int idx, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx[4:0]; pl_val = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
    mref[0][idx] = v;
    mref[1][idx] = v;
  endtask

  task automatic xact(input bit w, input logic [1:0] sz, input bit u,
                      input logic [31:0] a, input logic [31:0] d, input bit hold);
    int lat [2];
    int rd0 [2], wr0 [2], dn0 [2], ft0 [2], bh0 [2], ae0 [2];
    for (int k = 0; k < 2; k++) model(k, w, sz, u, a, d);
    exp_addr = {a[31:2], 2'b00};
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      rd0[k] = rd_cnt[k]; wr0[k] = wr_cnt[k]; dn0[k] = dn_cnt[k];
      ft0[k] = ft_cnt[k]; bh0[k] = bh_cnt[k]; ae0[k] = ae_cnt[k];
      lat[k] = 0;
    end
    @(negedge clk);
    req = 1'b1; req_write = w; req_size = sz; req_uns = u; req_addr = a; req_wdata = d;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (done[k] === 1'b1 && lat[k] == 0) begin
          lat[k] = c;
          chk($sformatf("fault%0d", k), {31'b0, fault[k]}, e_flt[k]);
          chk($sformatf("load%0d", k), load_data[k], mld[k]);
        end
      end
      if (!hold || lat[0] != 0 || lat[1] != 0) req = 1'b0;
      if (lat[0] != 0 && lat[1] != 0) break;
    end
    req = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      last_lat[k] = lat[k];
      chk($sformatf("lat%0d", k), lat[k], e_lat[k]);
      chk($sformatf("rd_n%0d", k), rd_cnt[k] - rd0[k], e_rd[k]);
      chk($sformatf("wr_n%0d", k), wr_cnt[k] - wr0[k], e_wr[k]);
      chk($sformatf("done_n%0d", k), dn_cnt[k] - dn0[k], 1);
      chk($sformatf("fault_n%0d", k), ft_cnt[k] - ft0[k], e_flt[k]);
      chk($sformatf("both%0d", k), bh_cnt[k] - bh0[k], 0);
      chk($sformatf("addr%0d", k), ae_cnt[k] - ae0[k], 0);
      chk($sformatf("busy%0d", k), {31'b0, busy[k]}, 0);
      chk($sformatf("ram%0d", k), ram[k][exp_idx], mref[k][exp_idx]);
    end
  endtask

  task automatic rst_mid();
    int wr0 [2], dn0 [2];
    exp_addr = 32'h24;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin wr0[k] = wr_cnt[k]; dn0[k] = dn_cnt[k]; end
    @(negedge clk);
    req = 1'b1; req_write = 1'b1; req_size = 2'd2; req_uns = 1'b0;
    req_addr = 32'h24; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    chk("rst_wr_strobe", {31'b0, mem_wr[0]}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      mld[k] = 32'h0;
      chk($sformatf("rst_wr_n%0d", k), wr_cnt[k] - wr0[k], 0);
      chk($sformatf("rst_done_n%0d", k), dn_cnt[k] - dn0[k], 0);
      chk($sformatf("rst_busy%0d", k), {31'b0, busy[k]}, 0);
      chk($sformatf("rst_ld%0d", k), load_data[k], mld[k]);
      chk($sformatf("rst_ram%0d", k), ram[k][9], mref[k][9]);
    end
    chk("rst_ram_lit", ram[0][9], 32'h8899_AABB);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit          w, u, mis, hold;
    logic [1:0]  sz;
    logic [31:0] a, d;
    rst = 1'b1; req = 1'b0; req_write = 1'b0; req_size = 2'd0; req_uns = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    mld[0] = 32'h0; mld[1] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_busy_init%0d", k), {31'b0, busy[k]}, 0);
      chk($sformatf("rst_done_init%0d", k), {31'b0, done[k]}, 0);
      chk($sformatf("rst_fault_init%0d", k), {31'b0, fault[k]}, 0);
      chk($sformatf("rst_rd_init%0d", k), {31'b0, mem_rd[k]}, 0);
      chk($sformatf("rst_wr_init%0d", k), {31'b0, mem_wr[k]}, 0);
      chk($sformatf("rst_addr_init%0d", k), mem_addr[k], 0);
      chk($sformatf("rst_wdata_init%0d", k), mem_wdata[k], 0);
      chk($sformatf("rst_ld_init%0d", k), load_data[k], 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 32; i++) pre(i, $urandom);
    pre(9, 32'h8899_AABB);

    xact(1'b0, 2'd0, 1'b0, 32'h25, 32'h0, 1'b0);
    chk("lb_signed", load_data[0], 32'hFFFF_FFAA);
    chk("lb_lat", last_lat[0], 2);
    xact(1'b0, 2'd0, 1'b1, 32'h25, 32'h0, 1'b0);
    chk("lb_unsigned", load_data[0], 32'h0000_00AA);
    xact(1'b0, 2'd1, 1'b0, 32'h26, 32'h0, 1'b0);
    chk("lh_signed", load_data[0], 32'hFFFF_8899);
    xact(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 1'b0);
    chk("lw", load_data[0], 32'h8899_AABB);
    xact(1'b1, 2'd0, 1'b0, 32'h27, 32'h11, 1'b0);
    chk("sb_lat", last_lat[0], 3);
    chk("sb_ram", ram[0][9], 32'h1199_AABB);
    xact(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 1'b0);
    chk("lw_after_sb", load_data[0], 32'h1199_AABB);
    xact(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b0);
    chk("fault_lat", last_lat[0], 1);
    chk("fault_ld_hold", load_data[0], 32'h1199_AABB);

    pre(9, 32'h8899_AABB);
    xact(1'b0, 2'd0, 1'b1, 32'h24, 32'h0, 1'b0);
    chk("be_lbu", load_data[1], 32'h0000_0088);
    xact(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 1'b1);
    rst_mid();

    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom;
      d  = $urandom;
      mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
      hold = !mis && ($urandom_range(0, 1) == 1);
      xact(w, sz, u, a, d, hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
